// File: rtl/axil_wr_adapter.sv
// rtl/axil_wr_adapter.sv - AXI4-Lite write-path adapter, one outstanding write
//
// Accepts AW and W from the slave side in any order, then replays them as a
// fully registered AW+W pair on the master side. The master B response is
// handed back to the slave side unmodified. Every output comes from a flop.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axil_aw*  (addr/valid/ready) slave write address channel
//   s_axil_w*   (data/strb/valid/ready) slave write data channel
//   s_axil_b*   (resp/valid/ready) slave write response channel
//   m_axil_aw*  (addr/valid/ready) master write address channel
//   m_axil_w*   (data/strb/valid/ready) master write data channel
//   m_axil_b*   (resp/valid/ready) master write response channel

module axil_wr_adapter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 32,
    localparam int S_STRB_WIDTH = S_DATA_WIDTH / 8,
    localparam int M_STRB_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [S_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [S_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [M_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [M_STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready
);

    if (M_DATA_WIDTH != S_DATA_WIDTH) begin : g_width_check
        $error("axil_wr_adapter: M_DATA_WIDTH must equal S_DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    aw_cap_q, aw_cap_d;
    logic                    w_cap_q, w_cap_d;
    logic                    s_awready_q, s_awready_d;
    logic                    s_wready_q, s_wready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [S_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [S_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                    m_awvalid_q, m_awvalid_d;
    logic                    m_wvalid_q, m_wvalid_d;
    logic                    m_bready_q, m_bready_d;
    logic                    s_bvalid_q, s_bvalid_d;
    logic [1:0]              s_bresp_q, s_bresp_d;

    logic aw_hs, w_hs;

    assign aw_hs = s_awready_q & s_axil_awvalid;
    assign w_hs  = s_wready_q & s_axil_wvalid;

    always_comb begin
        state_d     = state_q;
        aw_cap_d    = aw_cap_q;
        w_cap_d     = w_cap_q;
        s_awready_d = s_awready_q;
        s_wready_d  = s_wready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        s_bresp_d   = s_bresp_q;

        // Slave response retires independently of the FSM so IDLE can
        // already collect the next write while it is still pending.
        s_bvalid_d = s_bvalid_q & ~s_axil_bready;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    awaddr_d = s_axil_awaddr;
                    aw_cap_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d = s_axil_wdata;
                    wstrb_d = s_axil_wstrb;
                    w_cap_d = 1'b1;
                end
                if (aw_cap_d && w_cap_d) begin
                    state_d     = ISSUE;
                    m_awvalid_d = 1'b1;
                    m_wvalid_d  = 1'b1;
                    aw_cap_d    = 1'b0;
                    w_cap_d     = 1'b0;
                    s_awready_d = 1'b0;
                    s_wready_d  = 1'b0;
                end else begin
                    s_awready_d = ~aw_cap_d;
                    s_wready_d  = ~w_cap_d;
                end
            end
            ISSUE: begin
                if (m_awvalid_q && m_axil_awready) m_awvalid_d = 1'b0;
                if (m_wvalid_q && m_axil_wready)   m_wvalid_d  = 1'b0;
                if (!m_awvalid_d && !m_wvalid_d) begin
                    state_d    = RESP;
                    m_bready_d = ~s_bvalid_d;
                end
            end
            RESP: begin
                if (m_bready_q && m_axil_bvalid) begin
                    // m_bready was only high because s_bvalid was clearing,
                    // so the slave response slot is free here.
                    s_bresp_d   = m_axil_bresp;
                    s_bvalid_d  = 1'b1;
                    m_bready_d  = 1'b0;
                    state_d     = IDLE;
                    s_awready_d = 1'b1;
                    s_wready_d  = 1'b1;
                end else begin
                    m_bready_d = ~s_bvalid_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_cap_q    <= 1'b0;
            w_cap_q     <= 1'b0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            aw_cap_q    <= aw_cap_d;
            w_cap_q     <= w_cap_d;
            s_awready_q <= s_awready_d;
            s_wready_q  <= s_wready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            s_bvalid_q  <= s_bvalid_d;
            s_bresp_q   <= s_bresp_d;
        end
    end

    assign s_axil_awready = s_awready_q;
    assign s_axil_wready  = s_wready_q;
    assign s_axil_bresp   = s_bresp_q;
    assign s_axil_bvalid  = s_bvalid_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awvalid = m_awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = m_wvalid_q;
    assign m_axil_bready  = m_bready_q;

endmodule

// File: tb/tb_axil_wr_adapter.sv
// tb/tb_axil_wr_adapter.sv - self-checking bench for axil_wr_adapter

module tb_axil_wr_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] m_axil_awaddr;
    logic        m_axil_awvalid;
    logic        m_axil_awready = 1'b0;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready = 1'b0;
    logic [1:0]  m_axil_bresp = '0;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_bready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_wr_adapter #(
        .ADDR_WIDTH(32),
        .S_DATA_WIDTH(32),
        .M_DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .m_axil_awaddr(m_axil_awaddr),
        .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata),
        .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready)
    );

    task automatic abort_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout, actual=no event required=event within budget", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // One complete write: slave-side drivers, master-side responders and the
    // slave B acceptor run concurrently. Expected values are simply what this
    // task drove in; the response must come back exactly as the master sent it.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int maw_dly, input int mw_dly, input int mb_dly,
                            input int sb_dly, input logic [1:0] resp, input bit take_b);
        int aw_hs_cyc, w_hs_cyc, m_aw_first, m_w_first, exp_first;
        bit maw_done, mw_done, mb_done;
        maw_done = 1'b0;
        mw_done  = 1'b0;
        mb_done  = 1'b0;
        aw_hs_cyc = 0;
        w_hs_cyc  = 0;
        m_aw_first = -1;
        m_w_first  = -1;
        @(posedge clk); #1;
        fork
            begin : slv_aw
                int n;
                n = 0;
                repeat (aw_dly) begin @(posedge clk); #1; end
                s_axil_awaddr  = addr;
                s_axil_awvalid = 1'b1;
                @(negedge clk);
                while (!s_axil_awready) begin
                    n++;
                    if (n > 60) abort_timeout("slave_awready");
                    @(negedge clk);
                end
                @(posedge clk); #1;
                s_axil_awvalid = 1'b0;
                s_axil_awaddr  = $urandom;
                aw_hs_cyc = cyc;
                @(negedge clk);
                total++;
                if (s_axil_awready !== 1'b0) begin
                    bad++;
                    $display("FAIL awready_drop: got %b want 0", s_axil_awready);
                end
            end
            begin : slv_w
                int n;
                n = 0;
                repeat (w_dly) begin @(posedge clk); #1; end
                s_axil_wdata  = data;
                s_axil_wstrb  = strb;
                s_axil_wvalid = 1'b1;
                @(negedge clk);
                while (!s_axil_wready) begin
                    n++;
                    if (n > 60) abort_timeout("slave_wready");
                    @(negedge clk);
                end
                @(posedge clk); #1;
                s_axil_wvalid = 1'b0;
                s_axil_wdata  = $urandom;
                s_axil_wstrb  = 4'($urandom_range(0, 15));
                w_hs_cyc = cyc;
                @(negedge clk);
                total++;
                if (s_axil_wready !== 1'b0) begin
                    bad++;
                    $display("FAIL wready_drop: got %b want 0", s_axil_wready);
                end
            end
            begin : mst_aw
                int n;
                n = 0;
                @(negedge clk);
                while (!m_axil_awvalid) begin
                    n++;
                    if (n > 80) abort_timeout("m_awvalid");
                    @(negedge clk);
                end
                m_aw_first = cyc;
                total++;
                if (m_axil_awaddr !== addr) begin
                    bad++;
                    $display("FAIL m_awaddr: got %h want %h", m_axil_awaddr, addr);
                end
                repeat (maw_dly) begin
                    @(negedge clk);
                    total++;
                    if ({m_axil_awvalid, m_axil_awaddr} !== {1'b1, addr}) begin
                        bad++;
                        $display("FAIL m_aw_hold: got %b/%h want 1/%h",
                                 m_axil_awvalid, m_axil_awaddr, addr);
                    end
                end
                m_axil_awready = 1'b1;
                @(posedge clk);
                maw_done = 1'b1;
                @(negedge clk);
                m_axil_awready = 1'b0;
                total++;
                if (m_axil_awvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL m_awvalid_drop: got %b want 0", m_axil_awvalid);
                end
            end
            begin : mst_w
                int n;
                n = 0;
                @(negedge clk);
                while (!m_axil_wvalid) begin
                    n++;
                    if (n > 80) abort_timeout("m_wvalid");
                    @(negedge clk);
                end
                m_w_first = cyc;
                total++;
                if ({m_axil_wdata, m_axil_wstrb} !== {data, strb}) begin
                    bad++;
                    $display("FAIL m_wdata: got %h/%h want %h/%h",
                             m_axil_wdata, m_axil_wstrb, data, strb);
                end
                repeat (mw_dly) begin
                    @(negedge clk);
                    total++;
                    if ({m_axil_wvalid, m_axil_wdata, m_axil_wstrb} !== {1'b1, data, strb}) begin
                        bad++;
                        $display("FAIL m_w_hold: got %b/%h/%h want 1/%h/%h",
                                 m_axil_wvalid, m_axil_wdata, m_axil_wstrb, data, strb);
                    end
                end
                m_axil_wready = 1'b1;
                @(posedge clk);
                mw_done = 1'b1;
                @(negedge clk);
                m_axil_wready = 1'b0;
                total++;
                if (m_axil_wvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL m_wvalid_drop: got %b want 0", m_axil_wvalid);
                end
            end
            begin : mst_b
                int n;
                n = 0;
                @(negedge clk);
                while (!(maw_done && mw_done)) begin
                    total++;
                    if (m_axil_bready !== 1'b0) begin
                        bad++;
                        $display("FAIL early_bready: got %b want 0", m_axil_bready);
                    end
                    n++;
                    if (n > 160) abort_timeout("master_handshakes");
                    @(negedge clk);
                end
                repeat (mb_dly) @(negedge clk);
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = resp;
                n = 0;
                while (!m_axil_bready) begin
                    n++;
                    if (n > 80) abort_timeout("m_bready");
                    @(negedge clk);
                end
                total++;
                if (s_axil_bvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL bready_while_pending: s_bvalid got %b want 0", s_axil_bvalid);
                end
                @(posedge clk);
                mb_done = 1'b1;
                #1;
                m_axil_bvalid = 1'b0;
                m_axil_bresp  = ~resp;
                @(negedge clk);
                total++;
                if (m_axil_bready !== 1'b0) begin
                    bad++;
                    $display("FAIL m_bready_drop: got %b want 0", m_axil_bready);
                end
            end
            begin : slv_b
                int n;
                n = 0;
                if (take_b) begin
                    @(negedge clk);
                    while (!mb_done) begin
                        n++;
                        if (n > 300) abort_timeout("master_b");
                        @(negedge clk);
                    end
                    total++;
                    if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, resp}) begin
                        bad++;
                        $display("FAIL s_b: got %b/%b want 1/%b", s_axil_bvalid, s_axil_bresp, resp);
                    end
                    repeat (sb_dly) begin
                        @(negedge clk);
                        total++;
                        if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, resp}) begin
                            bad++;
                            $display("FAIL s_b_hold: got %b/%b want 1/%b",
                                     s_axil_bvalid, s_axil_bresp, resp);
                        end
                    end
                    s_axil_bready = 1'b1;
                    @(posedge clk); #1;
                    s_axil_bready = 1'b0;
                    @(negedge clk);
                    total++;
                    if (s_axil_bvalid !== 1'b0) begin
                        bad++;
                        $display("FAIL s_bvalid_clear: got %b want 0", s_axil_bvalid);
                    end
                end
            end
        join
        exp_first = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
        total++;
        if (m_aw_first !== exp_first) begin
            bad++;
            $display("FAIL issue_latency: m_awvalid at cycle %0d want %0d", m_aw_first, exp_first);
        end
        total++;
        if (m_w_first !== m_aw_first) begin
            bad++;
            $display("FAIL issue_together: m_wvalid at cycle %0d want %0d", m_w_first, m_aw_first);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, m_axil_awaddr,
                 m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got nonzero outputs want all 0 (awr=%b wr=%b bv=%b mawv=%b mwv=%b mbr=%b)",
                         s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid,
                         m_axil_wvalid, m_axil_bready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid,
             m_axil_wvalid, m_axil_bready} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_release: got %b want 110000",
                     {s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid,
                      m_axil_wvalid, m_axil_bready});
        end
    endtask

    task automatic test_same_cycle;
        do_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_w_first;
        do_write(32'h0000_0020, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_wready_stall;
        do_write(32'h0000_0030, 32'hA5A5_5A5A, 4'h9, 0, 0, 0, 5, 1, 1, 2'b01, 1'b1);
    endtask

    task automatic test_slverr_backpressure;
        do_write(32'h0000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 2'b10, 1'b0);
        fork
            begin
                total++;
                if ({s_axil_bvalid, s_axil_bresp} !== 3'b110) begin
                    bad++;
                    $display("FAIL slverr_b: got %b/%b want 1/10", s_axil_bvalid, s_axil_bresp);
                end
                repeat (4) begin
                    @(negedge clk);
                    total++;
                    if ({s_axil_bvalid, s_axil_bresp} !== 3'b110) begin
                        bad++;
                        $display("FAIL slverr_hold: got %b/%b want 1/10", s_axil_bvalid, s_axil_bresp);
                    end
                end
                s_axil_bready = 1'b1;
                @(posedge clk); #1;
                s_axil_bready = 1'b0;
                @(negedge clk);
                total++;
                if (s_axil_bvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL slverr_clear: got %b want 0", s_axil_bvalid);
                end
            end
            do_write(32'h0000_0044, 32'h0BAD_F00D, 4'hC, 0, 0, 0, 0, 0, 0, 2'b11, 1'b1);
        join
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        @(posedge clk); #1;
        s_axil_awaddr  = 32'h0000_0050;
        s_axil_awvalid = 1'b1;
        s_axil_wdata   = 32'h5555_AAAA;
        s_axil_wstrb   = 4'hF;
        s_axil_wvalid  = 1'b1;
        @(negedge clk);
        while (!m_axil_awvalid) begin
            n++;
            if (n > 20) abort_timeout("reset_mid_issue");
            @(negedge clk);
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid,
             m_axil_wvalid, m_axil_bready} !== 6'b000000) begin
            bad++;
            $display("FAIL reset_mid: got %b want 000000",
                     {s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid,
                      m_axil_wvalid, m_axil_bready});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({s_axil_awready, s_axil_wready, m_axil_awvalid, m_axil_wvalid} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_mid_release: got %b want 1100",
                     {s_axil_awready, s_axil_wready, m_axil_awvalid, m_axil_wvalid});
        end
        do_write(32'h0000_0060, 32'h600D_600D, 4'h6, 1, 0, 0, 0, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            do_write($urandom, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                     2'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_wready_stall();
        test_slverr_backpressure();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
